exu_lsu: RTL and testbench
==========================

# exu_lsu

Parametrised load/store unit for the execute stage, replacing the single-transaction memory sequencer. It accepts one load/store per cycle from the execute stage, issues it on the OBI-style data bus (req/gnt, then rvalid), and tracks up to `MAX_OUTSTANDING` in-flight transactions in an internal tracking FIFO. Byte lanes, sign/zero extension and destination register are applied in order when each response returns. Misaligned accesses are rejected before reaching the bus.

## Interface
- `MAX_OUTSTANDING`, default 2: tracking FIFO depth; legal range 1..8.
- `RD_W`, default 5: destination register index width.
- Reset `rst_n` is asynchronous, active-low; clock is `clk`.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid_i` input 1: execute stage presents a memory operation.
- `req_ready_o` output 1: operation consumed this cycle.
- `req_we_i` input 1: 1 = store, 0 = load.
- `req_size_i` input 2: 00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- `req_unsigned_i` input 1: load zero-extends (lbu/lhu); ignored for stores and word loads.
- `req_addr_i` input 32: byte address.
- `req_wdata_i` input 32: store data, LSB-aligned (rs2).
- `req_rd_i` input `RD_W`: load destination register.
- `data_req_o` output 1: bus request.
- `data_gnt_i` input 1: bus grant.
- `data_addr_o` output 32: word-aligned address, `{req_addr_i[31:2],2'b00}`.
- `data_we_o` output 1: bus write.
- `data_be_o` output 4: byte enables.
- `data_wdata_o` output 32: lane-shifted store data.
- `data_rvalid_i` input 1: bus response valid. Exactly one response per grant, in order.
- `data_rdata_i` input 32: bus read data.
- `rsp_valid_o` output 1: one transaction completed.
- `rsp_reg_we_o` output 1: completed transaction was a load; write `rsp_rd_o`.
- `rsp_rd_o` output `RD_W`: destination register.
- `rsp_rdata_o` output 32: extended load result; 0 for stores.
- `misaligned_o` output 1: rejected access; one-cycle pulse aligned with `req_ready_o`.
- `busy_o` output 1: FIFO non-empty or a request is pending ungranted. Used as the pipeline stall.

## Operation
- Misalignment: word with `addr[1:0]!=0`, half with `addr[0]=1`, or size 11.
  - Misaligned requests never assert `data_req_o`.
  - The unit asserts `req_ready_o=1` and `misaligned_o=1` in the same cycle and pushes nothing to the FIFO.
- Issue:
  - `data_req_o = req_valid_i & ~misaligned & ~full`.
  - `req_ready_o = misaligned | (data_gnt_i & data_req_o)`.
  - All `data_*` outputs are combinational from `req_*` and are held by the requester until granted.
- Byte enables, with `o = addr[1:0]`:
  - Byte: `1<<o`.
  - Half: `4'b0011<<o`.
  - Word: `4'b1111`.
- Store data:
  - Byte: `{4{wdata[7:0]}}`.
  - Half: `{2{wdata[15:0]}}`.
  - Word: `wdata`.
- Tracking FIFO:
  - On grant, push `{we, size, unsigned, o, rd}`.
  - On `data_rvalid_i`, pop the head.
  - The occupancy counter has `$clog2(MAX_OUTSTANDING+1)` bits. `full` means count equals `MAX_OUTSTANDING`.
  - A push and a pop in the same cycle leave the count unchanged, with pointers wrapping modulo depth. When full, no grant is accepted even if an rvalid occurs that cycle.
- Response formatting (combinational on the rvalid cycle):
  - Select the lane by the stored offset.
  - Byte: extend bit 7 of the selected byte. Half: extend bit 15 of the selected half.
  - The extension bit is zero when the unsigned flag is set.
  - `rsp_valid_o = data_rvalid_i & ~empty`.
  - `rsp_reg_we_o = rsp_valid_o & ~we`.
- `data_rvalid_i` while the FIFO is empty is ignored: no pop, no response.

## Timing
- Load latency: grant in cycle N; response appears in the same cycle rvalid arrives (N+1 at the earliest). There is no registered stage on the response path.
- Throughput: one grant per cycle while the FIFO is not full. `MAX_OUTSTANDING=1` reproduces the previous single-transaction behaviour.
- `busy_o = ~empty | (req_valid_i & ~req_ready_o)`.
- Reset values:
  - Count 0, pointers 0.
  - All response outputs are 0.
  - `data_req_o` follows its equation and is 0 when `req_valid_i=0`.
- Reset mid-operation: the FIFO is cleared immediately. Responses for transactions granted before reset are dropped, because the FIFO is empty.
- Rvalid and new grant in the same cycle with FIFO count 1: head pops, new entry pushes, count stays 1. The response comes from the old head.

## Test plan
- Load `lb` at address 0x1003, rdata 0x80_00_00_00 → be=4'b1000, rsp_rdata=0xFFFFFF80, rsp_reg_we=1. Repeat with `lbu` → 0x00000080.
- Store `sh` at address 0x2002, wdata 0x1234ABCD → data_be=4'b1100, data_wdata=0xABCDABCD. On rvalid: rsp_valid=1, rsp_reg_we=0.
- `lw` at address 0x3001 → misaligned_o=1, req_ready_o=1, data_req_o=0 in the same cycle, busy_o=0 the next cycle.
- `MAX_OUTSTANDING=2`: three back-to-back loads with gnt always high and rvalid delayed 3 cycles → the third stalls (`data_req_o=0`) until the first rvalid. Responses return in order with the correct rd values 1, 2, 3.
- Rvalid for the head and a new grant in the same cycle while full → new grant blocked. With count 1 → count stays 1 and the response comes from the old head.
- Reset asserted with 2 outstanding, followed by 2 stray rvalids → no rsp_valid_o, count stays 0.

Source files
------------

// File: rtl/exu_lsu.sv
// Execute-stage load/store unit: issues OBI-style data bus requests and keeps an in-order
// tracking FIFO so that up to MAX_OUTSTANDING loads/stores can be in flight at once.
module exu_lsu #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int RD_W            = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [31:0]     req_addr_i,
  input  logic [31:0]     req_wdata_i,
  input  logic [RD_W-1:0] req_rd_i,
  output logic            data_req_o,
  input  logic            data_gnt_i,
  output logic [31:0]     data_addr_o,
  output logic            data_we_o,
  output logic [3:0]      data_be_o,
  output logic [31:0]     data_wdata_o,
  input  logic            data_rvalid_i,
  input  logic [31:0]     data_rdata_i,
  output logic            rsp_valid_o,
  output logic            rsp_reg_we_o,
  output logic [RD_W-1:0] rsp_rd_o,
  output logic [31:0]     rsp_rdata_o,
  output logic            misaligned_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             misalign_raw;
  logic [1:0]       offset;

  logic            fifo_we   [MAX_OUTSTANDING];
  logic [1:0]      fifo_size [MAX_OUTSTANDING];
  logic            fifo_uns  [MAX_OUTSTANDING];
  logic [1:0]      fifo_off  [MAX_OUTSTANDING];
  logic [RD_W-1:0] fifo_rd   [MAX_OUTSTANDING];

  logic            head_we;
  logic [1:0]      head_size;
  logic            head_uns;
  logic [1:0]      head_off;
  logic [RD_W-1:0] head_rd;
  logic [31:0]     lane;
  logic [31:0]     load_data;

  assign offset = req_addr_i[1:0];
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);

  always_comb begin
    misalign_raw = 1'b0;
    case (req_size_i)
      SIZE_BYTE: misalign_raw = 1'b0;
      SIZE_HALF: misalign_raw = offset[0];
      SIZE_WORD: misalign_raw = (offset != 2'b00);
      default:   misalign_raw = 1'b1;
    endcase
  end

  // Misaligned accesses are consumed locally and never reach the bus or the FIFO.
  assign misaligned_o = req_valid_i & misalign_raw;
  assign data_req_o   = req_valid_i & ~misalign_raw & ~full;
  assign push         = data_req_o & data_gnt_i;
  assign pop          = data_rvalid_i & ~empty;
  assign req_ready_o  = misaligned_o | push;
  assign busy_o       = ~empty | (req_valid_i & ~req_ready_o);

  assign data_addr_o = {req_addr_i[31:2], 2'b00};
  assign data_we_o   = req_we_i;

  always_comb begin
    data_be_o    = 4'b1111;
    data_wdata_o = req_wdata_i;
    case (req_size_i)
      SIZE_BYTE: begin
        data_be_o    = 4'b0001 << offset;
        data_wdata_o = {4{req_wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        data_be_o    = 4'b0011 << offset;
        data_wdata_o = {2{req_wdata_i[15:0]}};
      end
      default: begin
        data_be_o    = 4'b1111;
        data_wdata_o = req_wdata_i;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed while the occupancy count says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr]   <= req_we_i;
      fifo_size[wr_ptr] <= req_size_i;
      fifo_uns[wr_ptr]  <= req_unsigned_i;
      fifo_off[wr_ptr]  <= offset;
      fifo_rd[wr_ptr]   <= req_rd_i;
    end
  end

  assign head_we   = fifo_we[rd_ptr];
  assign head_size = fifo_size[rd_ptr];
  assign head_uns  = fifo_uns[rd_ptr];
  assign head_off  = fifo_off[rd_ptr];
  assign head_rd   = fifo_rd[rd_ptr];

  assign lane = data_rdata_i >> {head_off, 3'b000};

  always_comb begin
    load_data = data_rdata_i;
    case (head_size)
      SIZE_BYTE: load_data = {{24{~head_uns & lane[7]}}, lane[7:0]};
      SIZE_HALF: load_data = {{16{~head_uns & lane[15]}}, lane[15:0]};
      default:   load_data = data_rdata_i;
    endcase
  end

  assign rsp_valid_o  = pop;
  assign rsp_reg_we_o = pop & ~head_we;
  assign rsp_rd_o     = pop ? head_rd : '0;
  assign rsp_rdata_o  = rsp_reg_we_o ? load_data : 32'h0;

endmodule

// File: tb/tb_exu_lsu.sv
// Directed self-checking bench for exu_lsu with the default depth of two outstanding accesses.
module tb_exu_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        rsp_valid_o;
  logic        rsp_reg_we_o;
  logic [4:0]  rsp_rd_o;
  logic [31:0] rsp_rdata_o;
  logic        misaligned_o;
  logic        busy_o;

  int checks;
  int errors;

  exu_lsu #(.MAX_OUTSTANDING(2), .RD_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i(req_we_i),
    .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_rd_i(req_rd_i),
    .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o),
    .data_we_o(data_we_o),
    .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_reg_we_o(rsp_reg_we_o),
    .rsp_rd_o(rsp_rd_o),
    .rsp_rdata_o(rsp_rdata_o),
    .misaligned_o(misaligned_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs just after the falling edge; checks follow before the next rising edge.
  task automatic applyStimulus(input logic valid, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd, input logic gnt, input logic rvalid,
                               input logic [31:0] rdata);
    @(negedge clk);
    req_valid_i    = valid;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_rd_i       = rd;
    data_gnt_i     = gnt;
    data_rvalid_i  = rvalid;
    data_rdata_i   = rdata;
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;
    req_addr_i     = 32'h0;
    req_wdata_i    = 32'h0;
    req_rd_i       = 5'd0;
    data_gnt_i     = 1'b0;
    data_rvalid_i  = 1'b0;
    data_rdata_i   = 32'h0;
    #2;
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
    checkOutput("reset_rsp_rdata", rsp_rdata_o, 32'h0);
    checkOutput("reset_data_req", {31'b0, data_req_o}, 32'h0);
    checkOutput("reset_busy", {31'b0, busy_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // lb at 0x1003, then its response
    applyStimulus(1, 0, 2'b00, 0, 32'h1003, 32'h0, 5'd7, 1, 0, 32'h0);
    checkOutput("lb_req", {31'b0, data_req_o}, 32'h1);
    checkOutput("lb_be", {28'b0, data_be_o}, 32'h8);
    checkOutput("lb_addr", data_addr_o, 32'h1000);
    checkOutput("lb_ready", {31'b0, req_ready_o}, 32'h1);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h8000_0000);
    checkOutput("lb_rsp_valid", {31'b0, rsp_valid_o}, 32'h1);
    checkOutput("lb_rsp_we", {31'b0, rsp_reg_we_o}, 32'h1);
    checkOutput("lb_rsp_rd", {27'b0, rsp_rd_o}, 32'd7);
    checkOutput("lb_rsp_data", rsp_rdata_o, 32'hFFFF_FF80);

    // lbu at 0x1003
    applyStimulus(1, 0, 2'b00, 1, 32'h1003, 32'h0, 5'd8, 1, 0, 32'h0);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h8000_0000);
    checkOutput("lbu_rsp_data", rsp_rdata_o, 32'h0000_0080);
    checkOutput("lbu_rsp_rd", {27'b0, rsp_rd_o}, 32'd8);

    // lh at 0x4002 picks the upper half and sign-extends
    applyStimulus(1, 0, 2'b01, 0, 32'h4002, 32'h0, 5'd9, 1, 0, 32'h0);
    checkOutput("lh_be", {28'b0, data_be_o}, 32'hC);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h8001_1234);
    checkOutput("lh_rsp_data", rsp_rdata_o, 32'hFFFF_8001);

    // lhu at 0x4000 zero-extends the lower half
    applyStimulus(1, 0, 2'b01, 1, 32'h4000, 32'h0, 5'd10, 1, 0, 32'h0);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h1234_F00F);
    checkOutput("lhu_rsp_data", rsp_rdata_o, 32'h0000_F00F);

    // sh at 0x2002
    applyStimulus(1, 1, 2'b01, 0, 32'h2002, 32'h1234_ABCD, 5'd3, 1, 0, 32'h0);
    checkOutput("sh_be", {28'b0, data_be_o}, 32'hC);
    checkOutput("sh_wdata", data_wdata_o, 32'hABCD_ABCD);
    checkOutput("sh_we", {31'b0, data_we_o}, 32'h1);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("sh_rsp_valid", {31'b0, rsp_valid_o}, 32'h1);
    checkOutput("sh_rsp_we", {31'b0, rsp_reg_we_o}, 32'h0);
    checkOutput("sh_rsp_data", rsp_rdata_o, 32'h0);

    // sb at 0x5001, granted a cycle late
    applyStimulus(1, 1, 2'b00, 0, 32'h5001, 32'h0000_00AB, 5'd0, 0, 0, 32'h0);
    checkOutput("sb_wait_ready", {31'b0, req_ready_o}, 32'h0);
    checkOutput("sb_wait_busy", {31'b0, busy_o}, 32'h1);
    checkOutput("sb_be", {28'b0, data_be_o}, 32'h2);
    checkOutput("sb_wdata", data_wdata_o, 32'hABAB_ABAB);
    applyStimulus(1, 1, 2'b00, 0, 32'h5001, 32'h0000_00AB, 5'd0, 1, 0, 32'h0);
    checkOutput("sb_ready", {31'b0, req_ready_o}, 32'h1);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h0);
    checkOutput("sb_rsp_valid", {31'b0, rsp_valid_o}, 32'h1);

    // lw at 0x3001 is rejected
    applyStimulus(1, 0, 2'b10, 0, 32'h3001, 32'h0, 5'd4, 1, 0, 32'h0);
    checkOutput("lw_mis_flag", {31'b0, misaligned_o}, 32'h1);
    checkOutput("lw_mis_ready", {31'b0, req_ready_o}, 32'h1);
    checkOutput("lw_mis_req", {31'b0, data_req_o}, 32'h0);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
    checkOutput("lw_mis_busy_next", {31'b0, busy_o}, 32'h0);

    // size 11 is rejected even when aligned
    applyStimulus(1, 0, 2'b11, 0, 32'h3000, 32'h0, 5'd4, 1, 0, 32'h0);
    checkOutput("size11_mis", {31'b0, misaligned_o}, 32'h1);
    checkOutput("size11_req", {31'b0, data_req_o}, 32'h0);

    // Three back-to-back lw with rvalid three cycles after the first grant
    applyStimulus(1, 0, 2'b10, 0, 32'h100, 32'h0, 5'd1, 1, 0, 32'h0);
    checkOutput("b2b_first_req", {31'b0, data_req_o}, 32'h1);
    applyStimulus(1, 0, 2'b10, 0, 32'h104, 32'h0, 5'd2, 1, 0, 32'h0);
    checkOutput("b2b_second_req", {31'b0, data_req_o}, 32'h1);
    applyStimulus(1, 0, 2'b10, 0, 32'h108, 32'h0, 5'd3, 1, 0, 32'h0);
    checkOutput("b2b_third_stall", {31'b0, data_req_o}, 32'h0);
    checkOutput("b2b_third_busy", {31'b0, busy_o}, 32'h1);
    applyStimulus(1, 0, 2'b10, 0, 32'h108, 32'h0, 5'd3, 1, 1, 32'h0000_0011);
    checkOutput("full_rvalid_blocks", {31'b0, data_req_o}, 32'h0);
    checkOutput("full_rvalid_ready", {31'b0, req_ready_o}, 32'h0);
    checkOutput("b2b_rsp1_rd", {27'b0, rsp_rd_o}, 32'd1);
    checkOutput("b2b_rsp1_data", rsp_rdata_o, 32'h0000_0011);
    applyStimulus(1, 0, 2'b10, 0, 32'h108, 32'h0, 5'd3, 1, 1, 32'h0000_0022);
    checkOutput("cnt1_push_pop_ready", {31'b0, req_ready_o}, 32'h1);
    checkOutput("b2b_rsp2_rd", {27'b0, rsp_rd_o}, 32'd2);
    checkOutput("b2b_rsp2_data", rsp_rdata_o, 32'h0000_0022);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h0000_0033);
    checkOutput("b2b_rsp3_valid", {31'b0, rsp_valid_o}, 32'h1);
    checkOutput("b2b_rsp3_rd", {27'b0, rsp_rd_o}, 32'd3);
    checkOutput("b2b_rsp3_data", rsp_rdata_o, 32'h0000_0033);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
    checkOutput("b2b_drained_busy", {31'b0, busy_o}, 32'h0);

    // Stray rvalid while empty produces nothing
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h1234_5678);
    checkOutput("stray_empty_rsp", {31'b0, rsp_valid_o}, 32'h0);

    // Reset with two outstanding, then two stray responses
    applyStimulus(1, 0, 2'b10, 0, 32'h200, 32'h0, 5'd5, 1, 0, 32'h0);
    applyStimulus(1, 0, 2'b10, 0, 32'h204, 32'h0, 5'd6, 1, 0, 32'h0);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
    checkOutput("pre_reset_busy", {31'b0, busy_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", {31'b0, busy_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'hAAAA_AAAA);
    checkOutput("post_reset_stray1", {31'b0, rsp_valid_o}, 32'h0);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'hBBBB_BBBB);
    checkOutput("post_reset_stray2", {31'b0, rsp_valid_o}, 32'h0);
    checkOutput("post_reset_busy", {31'b0, busy_o}, 32'h0);

    // A fresh load after reset still lines up with its own response
    applyStimulus(1, 0, 2'b00, 0, 32'h0002, 32'h0, 5'd12, 1, 0, 32'h0);
    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 1, 32'h0055_0000);
    checkOutput("post_reset_rd", {27'b0, rsp_rd_o}, 32'd12);
    checkOutput("post_reset_data", rsp_rdata_o, 32'h0000_0055);

    applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
